text_console: RTL and testbench



---
 rtl/text_console_if.sv | 31 +++
 rtl/text_console.sv | 163 ++++++++++++++++
 tb/tb_text_console.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/text_console_if.sv
// Byte-stream and text-RAM port bundle for the text console.
// master = the console itself, slave = the byte source / RAM side.
interface text_console_if #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = $clog2(2*ROWS*COLS)
) ();
  logic                     char_valid;
  logic [7:0]               char_data;
  logic [7:0]               char_attr;
  logic                     char_ready;
  logic                     busy;
  logic [$clog2(COLS)-1:0]  cursor_col;
  logic [$clog2(ROWS)-1:0]  cursor_row;
  logic [ADDR_W-1:0]        tram_addr;
  logic [15:0]              tram_wdata;
  logic [1:0]               tram_wenable;
  logic [15:0]              tram_rdata;

  modport master (
    input  char_valid, char_data, char_attr, tram_rdata,
    output char_ready, busy, cursor_col, cursor_row,
           tram_addr, tram_wdata, tram_wenable
  );

  modport slave (
    output char_valid, char_data, char_attr, tram_rdata,
    input  char_ready, busy, cursor_col, cursor_row,
           tram_addr, tram_wdata, tram_wenable
  );
endinterface

// File: rtl/text_console.sv
// Character-stream front end: writes {attr,char} cells at a hardware cursor,
// handles CR/LF/BS/FF, wraps lines and scrolls the text RAM up one row.
module text_console #(
  parameter int COLS   = 80,
  parameter int ROWS   = 30,
  parameter int ADDR_W = $clog2(2*ROWS*COLS)
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  text_console_if.master  bus
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);
  localparam int IDX_W = $clog2(ROWS*COLS);

  localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS-1);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS-1);
  localparam logic [IDX_W-1:0] COLS_IDX  = IDX_W'(COLS);
  localparam logic [IDX_W-1:0] SCR_LAST  = IDX_W'((ROWS-1)*COLS-1);
  localparam logic [IDX_W-1:0] CLR_FIRST = IDX_W'((ROWS-1)*COLS);
  localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(ROWS*COLS-1);

  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR} state_e;

  state_e             state_q;
  logic [COL_W-1:0]   col_q;
  logic [ROW_W-1:0]   row_q;
  logic [IDX_W-1:0]   idx_q;
  logic [7:0]         attr_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [15:0]        wdata_q;
  logic [1:0]         wen_q;
  logic               busy_q;

  logic [IDX_W-1:0]   put_idx_d;
  logic [IDX_W-1:0]   idx_inc_d;

  function automatic logic [ADDR_W-1:0] cell_addr(input logic [IDX_W-1:0] idx);
    return ADDR_W'({idx, 1'b0});
  endfunction

  always_comb begin
    put_idx_d = IDX_W'(row_q) * COLS_IDX + IDX_W'(col_q);
    idx_inc_d = idx_q + IDX_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      idx_q   <= '0;
      attr_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wen_q   <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.char_valid) begin
            attr_q <= bus.char_attr;
            case (bus.char_data)
              CH_CR: col_q <= '0;
              CH_BS: if (col_q != '0) col_q <= col_q - COL_W'(1);
              CH_LF: begin
                col_q <= '0;
                if (row_q != LAST_ROW) begin
                  row_q <= row_q + ROW_W'(1);
                end else begin
                  state_q <= SCR_RD;
                  idx_q   <= '0;
                  addr_q  <= cell_addr(COLS_IDX);
                  busy_q  <= 1'b1;
                end
              end
              CH_FF: begin
                col_q   <= '0;
                row_q   <= '0;
                state_q <= CLR;
                idx_q   <= '0;
                addr_q  <= cell_addr(IDX_W'(0));
                wdata_q <= {bus.char_attr, 8'h20};
                wen_q   <= 2'b11;
                busy_q  <= 1'b1;
              end
              default: begin
                state_q <= PUT;
                addr_q  <= cell_addr(put_idx_d);
                wdata_q <= {bus.char_attr, bus.char_data};
                wen_q   <= 2'b11;
              end
            endcase
          end
        end
        PUT: begin
          wen_q <= 2'b00;
          if (col_q != LAST_COL) begin
            col_q   <= col_q + COL_W'(1);
            state_q <= IDLE;
          end else begin
            col_q <= '0;
            if (row_q != LAST_ROW) begin
              row_q   <= row_q + ROW_W'(1);
              state_q <= IDLE;
            end else begin
              state_q <= SCR_RD;
              idx_q   <= '0;
              addr_q  <= cell_addr(COLS_IDX);
              busy_q  <= 1'b1;
            end
          end
        end
        SCR_RD: begin
          state_q <= SCR_WR;
          addr_q  <= cell_addr(idx_q);
          wen_q   <= 2'b11;
        end
        SCR_WR: begin
          // Keep the last moved word so wdata stays stable between writes.
          wdata_q <= bus.tram_rdata;
          if (idx_q == SCR_LAST) begin
            state_q <= CLR;
            idx_q   <= CLR_FIRST;
            addr_q  <= cell_addr(CLR_FIRST);
            wdata_q <= {attr_q, 8'h20};
          end else begin
            state_q <= SCR_RD;
            idx_q   <= idx_inc_d;
            addr_q  <= cell_addr(idx_inc_d + COLS_IDX);
            wen_q   <= 2'b00;
          end
        end
        CLR: begin
          if (idx_q == LAST_CELL) begin
            state_q <= IDLE;
            wen_q   <= 2'b00;
            busy_q  <= 1'b0;
          end else begin
            idx_q  <= idx_inc_d;
            addr_q <= cell_addr(idx_inc_d);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The RAM answers one cycle after SCR_RD, so the moved word is forwarded
  // straight through during SCR_WR instead of costing an extra cycle per cell.
  assign bus.char_ready   = (state_q == IDLE);
  assign bus.busy         = busy_q;
  assign bus.cursor_col   = col_q;
  assign bus.cursor_row   = row_q;
  assign bus.tram_addr    = addr_q;
  assign bus.tram_wdata   = (state_q == SCR_WR) ? bus.tram_rdata : wdata_q;
  assign bus.tram_wenable = wen_q;
endmodule

// File: tb/tb_text_console.sv
// Self-checking bench for text_console: directed steps plus random bytes,
// compared against a screen-image reference model and a text-RAM model.
module tb_text_console;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS*ROWS;

  logic sys_clk;
  logic rst_n;
  logic preloadReq;

  text_console_if #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(14)) bus ();

  text_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(14)) dut (
    .sys_clk (sys_clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic [15:0] ram [0:8191];
  int wrCount = 0;
  int busyCount = 0;
  int readyLowCount = 0;
  int badAddrCount = 0;
  logic [13:0] lastWrAddr = '0;
  logic [15:0] lastWrData = '0;

  // Synchronous text RAM (read-before-write) plus traffic monitor.
  always @(posedge sys_clk) begin
    if (preloadReq) begin
      for (int k = 0; k < 8192; k++) ram[k] <= 16'(k);
    end else if (bus.tram_wenable == 2'b11) begin
      ram[bus.tram_addr[13:1]] <= bus.tram_wdata;
    end
    bus.tram_rdata <= ram[bus.tram_addr[13:1]];
    if (bus.tram_wenable == 2'b11) begin
      wrCount++;
      lastWrAddr = bus.tram_addr;
      lastWrData = bus.tram_wdata;
      if (bus.tram_addr[0] || bus.tram_addr >= 14'd4800) badAddrCount++;
    end
    if (bus.busy === 1'b1) busyCount++;
    if (bus.char_ready === 1'b0) readyLowCount++;
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] screen [0:CELLS-1];
  int curRow = 0;
  int curCol = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelScroll(input logic [7:0] at);
    for (int k = 0; k < CELLS - COLS; k++) screen[k] = screen[k + COLS];
    for (int k = CELLS - COLS; k < CELLS; k++) screen[k] = {at, 8'h20};
  endtask

  // Screen-level model: returns the write count and busy / ready-low cycle
  // counts one byte should cost, and updates the expected image and cursor.
  task automatic modelByte(input logic [7:0] ch, input logic [7:0] at,
                           output int expWr, output int expBusy, output int expRl);
    int scrollCost;
    scrollCost = 2*(ROWS-1)*COLS + COLS;
    expWr = 0; expBusy = 0; expRl = 0;
    if (ch == 8'h0D) begin
      curCol = 0;
    end else if (ch == 8'h08) begin
      if (curCol > 0) curCol--;
    end else if (ch == 8'h0A) begin
      curCol = 0;
      if (curRow < ROWS-1) curRow++;
      else begin
        modelScroll(at);
        expWr = CELLS; expBusy = scrollCost; expRl = scrollCost;
      end
    end else if (ch == 8'h0C) begin
      for (int k = 0; k < CELLS; k++) screen[k] = {at, 8'h20};
      curRow = 0; curCol = 0;
      expWr = CELLS; expBusy = CELLS; expRl = CELLS;
    end else begin
      screen[curRow*COLS + curCol] = {at, ch};
      expWr = 1; expRl = 1;
      curCol++;
      if (curCol == COLS) begin
        curCol = 0;
        curRow++;
        if (curRow == ROWS) begin
          curRow = ROWS-1;
          modelScroll(at);
          expWr += CELLS; expBusy = scrollCost; expRl += scrollCost;
        end
      end
    end
  endtask

  function automatic int countDiff();
    int d = 0;
    for (int k = 0; k < CELLS; k++) if (ram[k] !== screen[k]) d++;
    return d;
  endfunction

  // Sends one byte, scribbles on the inputs while the console is not ready,
  // then checks cursor and per-byte cost against the model.
  task automatic applyStimulus(input logic [7:0] ch, input logic [7:0] at);
    int expWr, expBusy, expRl, wr0, busy0, rl0, n;
    modelByte(ch, at, expWr, expBusy, expRl);
    wr0 = wrCount; busy0 = busyCount; rl0 = readyLowCount;
    n = 0;
    while (bus.char_ready !== 1'b1 && n < 10000) begin
      @(negedge sys_clk);
      n++;
    end
    if (n >= 10000) checkOutput("ready_timeout", 32'(bus.char_ready), 32'd1);
    bus.char_valid = 1'b1;
    bus.char_data  = ch;
    bus.char_attr  = at;
    @(posedge sys_clk);
    #1;
    n = 0;
    do begin
      bus.char_valid = 1'($urandom);
      bus.char_data  = 8'($urandom);
      bus.char_attr  = 8'($urandom);
      @(negedge sys_clk);
      n++;
    end while (bus.char_ready !== 1'b1 && n < 10000);
    bus.char_valid = 1'b0;
    if (n >= 10000) checkOutput("idle_timeout", 32'(bus.char_ready), 32'd1);
    checkOutput("cursor_row", 32'(bus.cursor_row), 32'(curRow));
    checkOutput("cursor_col", 32'(bus.cursor_col), 32'(curCol));
    checkOutput("write_cycles", 32'(wrCount - wr0), 32'(expWr));
    checkOutput("busy_cycles", 32'(busyCount - busy0), 32'(expBusy));
    checkOutput("ready_low_cycles", 32'(readyLowCount - rl0), 32'(expRl));
  endtask

  task automatic doReset(input logic preload);
    @(negedge sys_clk);
    rst_n = 1'b0;
    bus.char_valid = 1'b0;
    preloadReq = preload;
    repeat (2) @(negedge sys_clk);
    rst_n = 1'b1;
    preloadReq = 1'b0;
    curRow = 0; curCol = 0;
    if (preload) for (int k = 0; k < CELLS; k++) screen[k] = 16'(k);
  endtask

  initial begin
    logic [7:0] ch;
    int r;
    rst_n = 1'b0;
    preloadReq = 1'b1;
    bus.char_valid = 1'b0;
    bus.char_data = '0;
    bus.char_attr = '0;

    doReset(1'b1);
    checkOutput("reset_ready", 32'(bus.char_ready), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_row", 32'(bus.cursor_row), 32'd0);
    checkOutput("reset_col", 32'(bus.cursor_col), 32'd0);
    checkOutput("reset_addr", 32'(bus.tram_addr), 32'd0);
    checkOutput("reset_wdata", 32'(bus.tram_wdata), 32'd0);
    checkOutput("reset_wen", 32'(bus.tram_wenable), 32'd0);

    // Single printable byte.
    applyStimulus(8'h41, 8'h1F);
    checkOutput("put_addr", 32'(lastWrAddr), 32'd0);
    checkOutput("put_data", 32'(lastWrData), 32'h1F41);

    // A full line wraps to the next row without scrolling.
    doReset(1'b0);
    for (int i = 0; i < COLS; i++) applyStimulus(8'h78, 8'h07);
    checkOutput("line_last_addr", 32'(lastWrAddr), 32'd158);
    checkOutput("line_ram", 32'(countDiff()), 32'd0);

    // Control codes from (2,5).
    applyStimulus(8'h0A, 8'h07);
    for (int i = 0; i < 5; i++) applyStimulus(8'h2E, 8'h07);
    applyStimulus(8'h08, 8'h07);
    applyStimulus(8'h0D, 8'h07);
    applyStimulus(8'h08, 8'h07);
    applyStimulus(8'h0A, 8'h07);

    // Scroll from (29,10) on a preloaded RAM.
    doReset(1'b1);
    for (int i = 0; i < ROWS-1; i++) applyStimulus(8'h0A, 8'h07);
    for (int i = 0; i < 10; i++) applyStimulus(8'($urandom_range(32, 126)), 8'($urandom));
    applyStimulus(8'h0A, 8'h20);
    checkOutput("scroll_ram", 32'(countDiff()), 32'd0);
    checkOutput("scroll_cell0", 32'(ram[0]), 32'd80);
    checkOutput("scroll_lastcell", 32'(ram[CELLS-1]), 32'h2020);
    applyStimulus(8'h41, 8'h1F);
    checkOutput("after_scroll_addr", 32'(lastWrAddr), 32'd4640);

    // Random byte stream from the home position.
    doReset(1'b0);
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 99);
      if (r < 8) ch = 8'h0A;
      else if (r < 14) ch = 8'h0D;
      else if (r < 20) ch = 8'h08;
      else ch = 8'($urandom_range(32, 126));
      applyStimulus(ch, 8'($urandom));
    end
    checkOutput("random_ram", 32'(countDiff()), 32'd0);

    // Form feed clears the whole screen.
    applyStimulus(8'h0C, 8'h1E);
    checkOutput("ff_ram", 32'(countDiff()), 32'd0);
    checkOutput("ff_last_addr", 32'(lastWrAddr), 32'd4798);

    // Reset in the middle of a scroll.
    for (int i = 0; i < ROWS-1; i++) applyStimulus(8'h0A, 8'h07);
    bus.char_valid = 1'b1;
    bus.char_data  = 8'h0A;
    bus.char_attr  = 8'h55;
    @(posedge sys_clk);
    #1;
    bus.char_valid = 1'b0;
    repeat (1000) @(negedge sys_clk);
    checkOutput("mid_scroll_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    @(negedge sys_clk);
    checkOutput("abort_wen", 32'(bus.tram_wenable), 32'd0);
    checkOutput("abort_busy", 32'(bus.busy), 32'd0);
    checkOutput("abort_row", 32'(bus.cursor_row), 32'd0);
    checkOutput("abort_col", 32'(bus.cursor_col), 32'd0);
    rst_n = 1'b1;
    curRow = 0; curCol = 0;
    @(negedge sys_clk);
    checkOutput("abort_ready", 32'(bus.char_ready), 32'd1);
    checkOutput("abort_wen_after", 32'(bus.tram_wenable), 32'd0);
    applyStimulus(8'h41, 8'h1F);
    checkOutput("abort_put_addr", 32'(lastWrAddr), 32'd0);

    checkOutput("bad_addresses", 32'(badAddrCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
